// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU sequencer slice.
// Contents:
//   state_t       - sequencer FSM states
//   cls_t         - instruction class field encoding
//   OP_*          - ALU opcode values as seen on alu_opcode
//   *_OFS         - instruction field positions, as offsets above the imm field
//                   (the imm field occupies bits [DATA_WIDTH-1:0])
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        HALTED    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_LDI  = 2'b01,
        CLS_HALT = 2'b10,
        CLS_NOP  = 2'b11
    } cls_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Each field is 2 bits wide; LSB position = DATA_WIDTH + offset.
    localparam int RS2_OFS = 0;
    localparam int RS1_OFS = 2;
    localparam int RD_OFS  = 4;
    localparam int OP_OFS  = 6;
    localparam int CLS_OFS = 8;

endpackage

// File: rtl/reg_file.sv
// Four-entry register file.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (clears all entries)
//   we/waddr/wdata  - single write port, written on the rising edge
//   raddr1/rdata1   - combinational read port 1
//   raddr2/rdata2   - combinational read port 2
module reg_file #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [1:0]            waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [1:0]            raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [1:0]            raddr2,
    output logic [DATA_WIDTH-1:0] rdata2
);

    logic [DATA_WIDTH-1:0] regs [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_sequencer.sv
// Control and operand stage in front of a 2-bit-opcode ALU.
// Accepts one instruction at a time, reads operands from a 4-entry register
// file, drives the ALU for one cycle, and writes the result back.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   instr_valid/instr_ready/instr_data - instruction input handshake
//   alu_a/alu_b/alu_opcode/alu_enable  - ALU drive (non-zero only in EXECUTE)
//   alu_out/alu_zero/alu_overflow      - ALU result and flags
//   result_valid/result_data/result_rd - one-cycle register-write strobe
//   zero_flag/overflow_flag            - flags of the last ALU instruction
//   pc                                 - accepted-instruction count (wraps)
//   halted                             - high while in HALTED
//
// Handshake: an instruction transfers on a rising edge where both
// instr_valid and instr_ready are high; instr_ready does not depend on
// instr_valid, and is high only in FETCH.
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PC_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [10+DATA_WIDTH-1:0] instr_data,
    output logic [DATA_WIDTH-1:0]    alu_a,
    output logic [DATA_WIDTH-1:0]    alu_b,
    output logic [1:0]               alu_opcode,
    output logic                     alu_enable,
    input  logic [DATA_WIDTH-1:0]    alu_out,
    input  logic                     alu_zero,
    input  logic                     alu_overflow,
    output logic                     result_valid,
    output logic [DATA_WIDTH-1:0]    result_data,
    output logic [1:0]               result_rd,
    output logic                     zero_flag,
    output logic                     overflow_flag,
    output logic [PC_WIDTH-1:0]      pc,
    output logic                     halted
);

    state_t state, state_next;

    logic [10+DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0]    op_a, op_b;
    logic [DATA_WIDTH-1:0]    res;
    logic                     cap_zero, cap_ovf;
    logic                     rf_we;
    logic [DATA_WIDTH-1:0]    rf_rd1, rf_rd2;

    // Instruction register fields.
    cls_t                  ir_cls;
    logic [1:0]            ir_op, ir_rd, ir_rs1, ir_rs2;
    logic [DATA_WIDTH-1:0] ir_imm;

    assign ir_cls = cls_t'(ir[DATA_WIDTH+CLS_OFS +: 2]);
    assign ir_op  = ir[DATA_WIDTH+OP_OFS  +: 2];
    assign ir_rd  = ir[DATA_WIDTH+RD_OFS  +: 2];
    assign ir_rs1 = ir[DATA_WIDTH+RS1_OFS +: 2];
    assign ir_rs2 = ir[DATA_WIDTH+RS2_OFS +: 2];
    assign ir_imm = ir[DATA_WIDTH-1:0];

    reg_file #(.DATA_WIDTH(DATA_WIDTH)) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (ir_rd),
        .wdata  (res),
        .raddr1 (ir_rs1),
        .rdata1 (rf_rd1),
        .raddr2 (ir_rs2),
        .rdata2 (rf_rd2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        instr_ready  = 1'b0;
        alu_enable   = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_opcode   = 2'b00;
        result_valid = 1'b0;
        result_data  = '0;
        result_rd    = 2'b00;
        halted       = 1'b0;
        rf_we        = 1'b0;
        case (state)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (ir_cls)
                    CLS_ALU:  state_next = EXECUTE;
                    CLS_LDI:  state_next = WRITEBACK;
                    CLS_HALT: state_next = HALTED;
                    default:  state_next = FETCH;
                endcase
            end
            EXECUTE: begin
                alu_enable = 1'b1;
                alu_a      = op_a;
                alu_b      = op_b;
                alu_opcode = ir_op;
                state_next = WRITEBACK;
            end
            WRITEBACK: begin
                rf_we        = 1'b1;
                result_valid = 1'b1;
                result_data  = res;
                result_rd    = ir_rd;
                state_next   = FETCH;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Datapath registers; each is loaded only in the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir            <= '0;
            op_a          <= '0;
            op_b          <= '0;
            res           <= '0;
            cap_zero      <= 1'b0;
            cap_ovf       <= 1'b0;
            pc            <= '0;
            zero_flag     <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir <= instr_data;
                        pc <= pc + PC_WIDTH'(1);
                    end
                end
                DECODE: begin
                    op_a <= rf_rd1;
                    op_b <= rf_rd2;
                    if (ir_cls == CLS_LDI) begin
                        res <= ir_imm;
                    end
                end
                EXECUTE: begin
                    res      <= alu_out;
                    cap_zero <= alu_zero;
                    cap_ovf  <= alu_overflow;
                end
                WRITEBACK: begin
                    // LDI writes a register but must not disturb the flags.
                    if (ir_cls == CLS_ALU) begin
                        zero_flag     <= cap_zero;
                        overflow_flag <= cap_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Control and operand stage directly upstream of the 2-bit-opcode ALU.
- Accepts instructions over a valid/ready handshake and holds a 4-entry register file.
- Drives the ALU's a/b/opcode/enable inputs for one cycle per ALU instruction.
- Captures the ALU result and flags, writes the result back, and publishes it as a one-cycle result strobe.
- Sequenced by a multi-cycle FSM: FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.

Parameters:
- DATA_WIDTH, 8, operand, register and ALU data width.
- PC_WIDTH, 8, width of the accepted-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  upstream instruction present.
- instr_ready  output  1  block can accept an instruction this cycle.
- instr_data  input  10+DATA_WIDTH  instruction word, MSB first: {cls[1:0], op[1:0], rd[1:0], rs1[1:0], rs2[1:0], imm[DATA_WIDTH-1:0]}.
- alu_a  output  DATA_WIDTH  ALU operand a.
- alu_b  output  DATA_WIDTH  ALU operand b.
- alu_opcode  output  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR.
- alu_enable  output  1  ALU enable.
- alu_out  input  DATA_WIDTH  ALU result (combinational from alu_a/alu_b/alu_opcode).
- alu_zero  input  1  ALU zero flag.
- alu_overflow  input  1  ALU carry/borrow-out flag.
- result_valid  output  1  one-cycle strobe: a register was written.
- result_data  output  DATA_WIDTH  value written.
- result_rd  output  2  destination register index.
- zero_flag  output  1  registered zero status of the last ALU instruction.
- overflow_flag  output  1  registered overflow status of the last ALU instruction.
- pc  output  PC_WIDTH  count of accepted instructions; wraps modulo 2^PC_WIDTH.
- halted  output  1  high while in HALTED.

Behaviour:
- Reset (synchronous, active-high):
  - state = FETCH; all four registers, the instruction register, the operand latches and pc = 0.
  - All outputs = 0, except instr_ready = 1 in the first cycle after reset.
  - rst overrides everything, including mid-EXECUTE or mid-WRITEBACK; no register write occurs in the reset cycle.
- Instruction classes (cls):
  - 00 ALU: rd = rs1 op rs2.
  - 01 LDI: rd = imm.
  - 10 HALT.
  - 11 NOP.
- FETCH:
  - instr_ready = 1.
  - On instr_valid & instr_ready: latch instr_data, pc <= pc+1, go to DECODE.
  - Otherwise stay in FETCH; no side effects.
- DECODE: instr_ready = 0; read rs1/rs2 into the operand latches.
  - ALU → EXECUTE.
  - LDI → WRITEBACK with the result set to imm.
  - HALT → HALTED.
  - NOP → FETCH.
- EXECUTE: alu_enable = 1, with alu_a/alu_b/alu_opcode driven from the operand latches. At the clock edge, capture alu_out, alu_zero and alu_overflow, then go to WRITEBACK.
- WRITEBACK:
  - Write the result to rd.
  - result_valid = 1, with result_data/result_rd valid in the same cycle.
  - For ALU instructions only, update zero_flag/overflow_flag from the captured values. LDI leaves the flags unchanged.
  - Then go to FETCH.
- ALU port defaults: outside EXECUTE, alu_enable = 0 and alu_a/alu_b/alu_opcode = 0.
- Latency, measured from the handshake cycle T:
  - ALU instruction: result_valid at T+3; next instr_ready at T+4.
  - LDI: result_valid at T+2.
  - NOP: instr_ready again at T+2.
- Maximum throughput: one ALU instruction per 4 cycles.
- Hazards: rd equal to rs1 or rs2 is legal. Execution is strictly sequential, so the next instruction sees the written value.
- Arithmetic: no internal arithmetic beyond pc. Overflow semantics are exactly the ALU's carry/borrow bit; AND and OR yield overflow 0.
- HALTED: instr_ready = 0 and halted = 1; remains there until rst. instr_valid is ignored.
- pc wraps from 2^PC_WIDTH-1 to 0 with no flag.

Decomposition:
- Package cpu_pkg:
  - state enum {FETCH, DECODE, EXECUTE, WRITEBACK, HALTED};
  - class enum {CLS_ALU, CLS_LDI, CLS_HALT, CLS_NOP};
  - ALU op constants ADD/SUB/AND/OR;
  - instruction field bit-position constants.
- Sub-module reg_file: 4 x DATA_WIDTH, 2 combinational read ports, 1 write port, synchronous active-high reset to 0.

Test Plan:
- Basic ADD: reset; LDI R1=5, LDI R2=3, ALU ADD R3=R1+R2 → result_valid 3 cycles after the ADD handshake, result_data=8, result_rd=3, zero_flag=0, overflow_flag=0, pc=3.
- SUB to zero: LDI R1=200, LDI R2=100, ADD R0=R1+R2 → result_data=44, overflow_flag=1. Then SUB R0=R1-R1 → result_data=0, zero_flag=1, overflow_flag=0.
- Borrow: LDI R1=3, LDI R2=5, SUB R3=R1-R2 → result_data=254, overflow_flag=1. A following LDI R0=0 leaves both flags unchanged.
- Backpressure and NOP: hold instr_valid low 5 cycles → instr_ready stays 1, pc unchanged, alu_enable 0. Then a NOP → no result_valid, instr_ready back at T+2.
- HALT: issue HALT, then hold instr_valid=1 → halted=1, instr_ready=0 indefinitely, pc unchanged. Asserting rst → FETCH, pc=0, halted=0.
- Reset mid-operation: assert rst in the EXECUTE cycle of ADD R3 → no result_valid; R3 reads 0 on a later ADD R0=R3+R3 (result_data=0, zero_flag=1).
